multicycle_seq_ctrl: RTL and testbench
======================================

// Module: multicycle_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the R-type datapath: fetches an instruction over a req/ack port, decodes
//  opcode/fn_code, and drives ALU_cntrl, RegWrite and ALUtoReg for one instruction at a time.
//  Starts and waits on an external multiply/divide unit. Replaces single-cycle control in the CPU top.
// PARAMETERS
//  MD_TIMEOUT  64  max cycles waiting for md_done before entering ERROR
//  CNT_W       16  width of retired-instruction counter
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  run          in   1   level; enables sequencing; sampled in IDLE and WB only
//  imem_req     out  1   fetch request; held high until imem_ack
//  imem_ack     in   1   fetch accepted; imem_rdata valid same cycle
//  imem_rdata   in   32  instruction word
//  ir           out  32  latched instruction register
//  alu_cntrl    out  3   ALU operation select
//  md_start     out  1   one-cycle pulse to start mult/div unit
//  md_op        out  1   0=mult, 1=div; valid with md_start, held through MDWAIT
//  md_done      in   1   mult/div result valid, single-cycle pulse
//  RegWrite     out  1   register-file write enable, one cycle in WB
//  ALUtoReg     out  1   1=ALU result to reg file, 0=mult/div result
//  pc_inc       out  1   one-cycle pulse advancing PC
//  busy         out  1   high in every state except IDLE, HALT, ERROR
//  illegal      out  1   one-cycle pulse on undecodable instruction
//  halted       out  1   sticky; HALT or ERROR reached
//  error        out  1   sticky; mult/div timeout
//  retired      out  CNT_W  instructions completed through WB; saturates at all-ones
// BEHAVIOUR
//  - Reset: state=IDLE; ir=0; alu_cntrl=3'b010; all 1-bit outputs 0; retired=0.
//  - Decode (ir[31:26]=op, ir[5:0]=fn): op=6'h00 with fn 20 add/22 sub/24 and/25 or/2A slt -> ALU.
//    op=0 fn 18 mult/1A div -> MD. op=6'h3F -> HALT. Any other op/fn -> illegal.
//  - ALU encoding: AND=000 OR=001 ADD=010 SUB=110 SLT=111. alu_cntrl registered in DECODE,
//    held until next DECODE.
//  - IDLE: run=1 -> FETCH.
//  - FETCH: imem_req=1. On imem_ack, ir<=imem_rdata, imem_req drops next cycle -> DECODE.
//    No timeout. Fetch is never abandoned; run is ignored here.
//  - DECODE (1 cycle): ALU -> EXEC. MD -> MDWAIT with md_start pulsed on transition.
//    HALT -> HALT. Illegal -> illegal=1, pc_inc=1 for 1 cycle, then FETCH if run else IDLE.
//    No write and no retire count.
//  - EXEC (1 cycle) -> WB, ALUtoReg=1.
//  - MDWAIT: ALUtoReg=0; cycle counter from 0. md_done -> WB.
//    Counter reaching MD_TIMEOUT without md_done -> ERROR.
//    md_done on the same cycle as the timeout wins (goes to WB).
//  - WB (1 cycle): RegWrite=1, pc_inc=1, retired+=1 (saturating). run ? FETCH : IDLE.
//  - HALT / ERROR: terminal until rst_n. halted=1; ERROR also sets error=1. imem_req=0, RegWrite=0.
//  - md_done outside MDWAIT is ignored. imem_ack outside FETCH is ignored.
//  - rst_n low mid-instruction aborts immediately: no WB, no pc_inc, all outputs at reset values.
//  - Min latency with imem_ack in the request cycle: ALU op = 4 cycles (FETCH, DECODE, EXEC, WB).
//    MD op = 3 + mult/div unit latency.
// STRUCTURE
//  - Package ctrl_pkg: opcode/funct localparams, ALU_cntrl encodings, state enum
//    (IDLE, FETCH, DECODE, EXEC, MDWAIT, WB, HALT, ERROR).
//  - One sub-module, instr_decode: combinational ir -> {class, alu_cntrl, md_op}.
//  - FSM, timeout counter and retired counter stay in this module.
// TESTING
//  1. run=1, ack same cycle, ir=32'h00851020 (add) -> DECODE sets alu_cntrl=010, RegWrite=1 at cycle 4,
//     retired=1.
//  2. ack delayed 3 cycles -> imem_req high for exactly 4 cycles; ir unchanged until the ack cycle.
//  3. fn=6'h18, md_done 5 cycles after md_start -> md_op=0, ALUtoReg=0 in WB, one RegWrite pulse.
//  4. fn=6'h1A, md_done never -> ERROR after 64 MDWAIT cycles; error=halted=1; no further imem_req.
//  5. op=6'h3F -> halted=1, busy=0, retired unchanged. op=6'h23 -> illegal pulse, pc_inc pulse,
//     no RegWrite, next fetch issued.
//  6. rst_n low during MDWAIT -> all outputs reset asynchronously. Late md_done after release ignored.
//     run=0 in WB -> returns to IDLE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle R-type sequencer: opcode/funct values,
// ALU control codes, instruction classes and controller states.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MD,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_class_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MDWAIT,
    WB,
    HALT,
    ERROR
  } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational classifier: opcode/funct -> instruction class, ALU select and
// mult/div operation. Non-ALU instructions report the ADD encoding.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]   op_i,
  input  logic [5:0]   fn_i,
  output instr_class_e cls_o,
  output logic [2:0]   alu_cntrl_o,
  output logic         md_op_o
);

  always_comb begin
    cls_o       = CLS_ILLEGAL;
    alu_cntrl_o = ALU_ADD;
    md_op_o     = 1'b0;
    if (op_i == OP_HALT) begin
      cls_o = CLS_HALT;
    end else if (op_i == OP_RTYPE) begin
      case (fn_i)
        FN_ADD:  begin cls_o = CLS_ALU; alu_cntrl_o = ALU_ADD; end
        FN_SUB:  begin cls_o = CLS_ALU; alu_cntrl_o = ALU_SUB; end
        FN_AND:  begin cls_o = CLS_ALU; alu_cntrl_o = ALU_AND; end
        FN_OR:   begin cls_o = CLS_ALU; alu_cntrl_o = ALU_OR;  end
        FN_SLT:  begin cls_o = CLS_ALU; alu_cntrl_o = ALU_SLT; end
        FN_MULT: begin cls_o = CLS_MD;  md_op_o = 1'b0; end
        FN_DIV:  begin cls_o = CLS_MD;  md_op_o = 1'b1; end
        default: cls_o = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencer: fetch over req/ack, decode, ALU or mult/div execute,
// single-cycle write-back, with a mult/div timeout and a retired-instruction count.
module multicycle_seq_ctrl
  import ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  output logic [2:0]       alu_cntrl,
  output logic             md_start,
  output logic             md_op,
  input  logic             md_done,
  output logic             RegWrite,
  output logic             ALUtoReg,
  output logic             pc_inc,
  output logic             busy,
  output logic             illegal,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  localparam int TO_W = $clog2(MD_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [31:0]       ir_q;
  logic [2:0]        alu_q;
  logic              alu_to_reg_q;
  logic [TO_W-1:0]   md_cnt_q;
  logic [CNT_W-1:0]  retired_q;

  instr_class_e      dec_cls;
  logic [2:0]        dec_alu;
  logic              dec_md_op;

  instr_decode u_decode (
    .op_i        (ir_q[31:26]),
    .fn_i        (ir_q[5:0]),
    .cls_o       (dec_cls),
    .alu_cntrl_o (dec_alu),
    .md_op_o     (dec_md_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ir_q         <= '0;
      alu_q        <= ALU_ADD;
      alu_to_reg_q <= 1'b0;
      md_cnt_q     <= '0;
      retired_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && imem_ack) ir_q <= imem_rdata;
      if (state_q == DECODE) alu_q <= dec_alu;
      if (state_q == EXEC) alu_to_reg_q <= 1'b1;
      else if (state_q == MDWAIT) alu_to_reg_q <= 1'b0;
      // Wait counter restarts at zero on every entry into MDWAIT.
      md_cnt_q <= (state_q == MDWAIT) ? md_cnt_q + TO_W'(1) : '0;
      if (state_q == WB && retired_q != '1) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    md_start = 1'b0;
    md_op    = 1'b0;
    RegWrite = 1'b0;
    ALUtoReg = alu_to_reg_q;
    pc_inc   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = DECODE;
      end
      DECODE: begin
        case (dec_cls)
          CLS_ALU:  state_d = EXEC;
          CLS_MD: begin
            md_start = 1'b1;
            md_op    = dec_md_op;
            state_d  = MDWAIT;
          end
          CLS_HALT: state_d = HALT;
          default: begin
            illegal = 1'b1;
            pc_inc  = 1'b1;
            state_d = run ? FETCH : IDLE;
          end
        endcase
      end
      EXEC: begin
        ALUtoReg = 1'b1;
        state_d  = WB;
      end
      MDWAIT: begin
        ALUtoReg = 1'b0;
        md_op    = dec_md_op;
        // A completion in the final allowed cycle still beats the timeout.
        if (md_done) state_d = WB;
        else if (md_cnt_q == TO_W'(MD_TIMEOUT - 1)) state_d = ERROR;
      end
      WB: begin
        RegWrite = 1'b1;
        pc_inc   = 1'b1;
        state_d  = run ? FETCH : IDLE;
      end
      default: state_d = state_q;
    endcase
  end

  assign ir        = ir_q;
  assign alu_cntrl = alu_q;
  assign busy      = !(state_q inside {IDLE, HALT, ERROR});
  assign halted    = (state_q == HALT) || (state_q == ERROR);
  assign error     = (state_q == ERROR);
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Scoreboard bench for multicycle_seq_ctrl: expected write-back / illegal events
// are queued as instructions are served and matched when the DUT produces them.
module tb_multicycle_seq_ctrl;

  logic        clk, rst_n, run;
  logic        imem_req, imem_ack;
  logic [31:0] imem_rdata, ir;
  logic [2:0]  alu_cntrl;
  logic        md_start, md_op, md_done;
  logic        RegWrite, ALUtoReg, pc_inc, busy, illegal, halted, error;
  logic [15:0] retired;

  typedef struct {
    int         kind;
    logic [2:0] alu;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   lastReqCycles = 0;

  localparam int K_ALU = 0, K_MD = 1, K_ILL = 2;

  multicycle_seq_ctrl #(.MD_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .alu_cntrl(alu_cntrl), .md_start(md_start), .md_op(md_op),
    .md_done(md_done), .RegWrite(RegWrite), .ALUtoReg(ALUtoReg),
    .pc_inc(pc_inc), .busy(busy), .illegal(illegal), .halted(halted),
    .error(error), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Waits (bounded) for a fetch request, acks it after ackDelay cycles and
  // returns at the negedge of the DECODE cycle.
  task automatic applyStimulus(input logic [31:0] instr, input int ackDelay);
    int          n = 0;
    int          reqCycles = 0;
    logic [31:0] irBefore;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      checkOutput("fetchTimeout", 32'd0, 32'd1);
      return;
    end
    irBefore = ir;
    repeat (ackDelay) begin
      reqCycles += int'(imem_req);
      @(negedge clk);
    end
    reqCycles += int'(imem_req);
    checkOutput("irHeld", ir, irBefore);
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEADBEEF;
    checkOutput("irLoad", ir, instr);
    checkOutput("reqDrop", {31'd0, imem_req}, 32'd0);
    lastReqCycles = reqCycles;
  endtask

  // Scoreboard consumer: every write-back or illegal pulse must match the
  // oldest queued expectation.
  always @(negedge clk) begin
    if (RegWrite || illegal) begin
      int   obsKind;
      exp_t e;
      if (illegal && RegWrite) obsKind = 3;
      else if (illegal)        obsKind = K_ILL;
      else if (ALUtoReg)       obsKind = K_ALU;
      else                     obsKind = K_MD;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedEvent", 32'(obsKind), 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("sbKind", 32'(obsKind), 32'(e.kind));
        checkOutput("sbPcInc", {31'd0, pc_inc}, 32'd1);
        if (e.kind == K_ALU) checkOutput("sbAlu", {29'd0, alu_cntrl}, {29'd0, e.alu});
      end
    end
  end

  initial begin
    int n;
    logic sawReq;
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0; md_done = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstReq", {31'd0, imem_req}, 32'd0);
    checkOutput("rstIr", ir, 32'd0);
    checkOutput("rstAlu", {29'd0, alu_cntrl}, 32'd2);
    checkOutput("rstRetired", {16'd0, retired}, 32'd0);
    checkOutput("rstFlags", {28'd0, halted, error, RegWrite, pc_inc}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] add, immediate ack");
    run = 1'b1;
    expQ.push_back('{K_ALU, 3'b010});
    applyStimulus(32'h00851020, 0);
    @(negedge clk);
    checkOutput("t1Alu", {29'd0, alu_cntrl}, 32'd2);
    @(negedge clk);
    checkOutput("t1RegWrite", {31'd0, RegWrite}, 32'd1);
    @(negedge clk);
    checkOutput("t1Retired", {16'd0, retired}, 32'd1);

    $display("[TB] sub, ack delayed 3 cycles");
    expQ.push_back('{K_ALU, 3'b110});
    applyStimulus(32'h00851022, 3);
    checkOutput("t2ReqCycles", 32'(lastReqCycles), 32'd4);
    @(negedge clk);
    checkOutput("t2Alu", {29'd0, alu_cntrl}, 32'd6);
    repeat (2) @(negedge clk);
    checkOutput("t2Retired", {16'd0, retired}, 32'd2);

    $display("[TB] mult, md_done after 5 cycles");
    expQ.push_back('{K_MD, 3'b010});
    applyStimulus(32'h00851018, 0);
    checkOutput("t3MdStart", {31'd0, md_start}, 32'd1);
    checkOutput("t3MdOp", {31'd0, md_op}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("t3WaitMdStart", {31'd0, md_start}, 32'd0);
    checkOutput("t3WaitAluToReg", {31'd0, ALUtoReg}, 32'd0);
    md_done = 1'b1;
    @(negedge clk);
    md_done = 1'b0;
    checkOutput("t3RegWrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("t3AluToReg", {31'd0, ALUtoReg}, 32'd0);
    @(negedge clk);
    checkOutput("t3SinglePulse", {31'd0, RegWrite}, 32'd0);
    checkOutput("t3Retired", {16'd0, retired}, 32'd3);

    $display("[TB] illegal opcode 0x23");
    expQ.push_back('{K_ILL, 3'b010});
    applyStimulus(32'h8C000000, 0);
    checkOutput("t5Illegal", {31'd0, illegal}, 32'd1);
    checkOutput("t5NoWrite", {31'd0, RegWrite}, 32'd0);
    @(negedge clk);
    checkOutput("t5NextFetch", {31'd0, imem_req}, 32'd1);
    checkOutput("t5Retired", {16'd0, retired}, 32'd3);

    $display("[TB] div, md_done on the last allowed cycle");
    expQ.push_back('{K_MD, 3'b010});
    applyStimulus(32'h0085101A, 0);
    checkOutput("tbMdOp", {31'd0, md_op}, 32'd1);
    repeat (64) @(negedge clk);
    checkOutput("tbStillWaiting", {30'd0, busy, error}, 32'd2);
    md_done = 1'b1;
    @(negedge clk);
    md_done = 1'b0;
    checkOutput("tbRegWrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("tbNoError", {31'd0, error}, 32'd0);
    @(negedge clk);
    checkOutput("tbRetired", {16'd0, retired}, 32'd4);

    $display("[TB] reset during MDWAIT");
    applyStimulus(32'h0085101A, 0);
    repeat (3) @(negedge clk);
    checkOutput("t6BusyBefore", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6Busy", {31'd0, busy}, 32'd0);
    checkOutput("t6MdOp", {31'd0, md_op}, 32'd0);
    checkOutput("t6Ir", ir, 32'd0);
    checkOutput("t6Retired", {16'd0, retired}, 32'd0);
    checkOutput("t6Alu", {29'd0, alu_cntrl}, 32'd2);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    md_done = 1'b1;
    @(negedge clk);
    md_done = 1'b0;
    checkOutput("t6LateDone", {30'd0, busy, RegWrite}, 32'd0);

    $display("[TB] and, run dropped before WB");
    run = 1'b1;
    expQ.push_back('{K_ALU, 3'b000});
    applyStimulus(32'h00851024, 0);
    run = 1'b0;
    @(negedge clk);
    checkOutput("t6Alu", {29'd0, alu_cntrl}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("t6Idle", {30'd0, busy, imem_req}, 32'd0);
    checkOutput("t6RetiredAnd", {16'd0, retired}, 32'd1);

    $display("[TB] halt");
    run = 1'b1;
    applyStimulus(32'hFC000000, 0);
    @(negedge clk);
    checkOutput("t5Halted", {29'd0, halted, busy, error}, 32'd4);
    repeat (5) @(negedge clk);
    checkOutput("t5HaltNoReq", {31'd0, imem_req}, 32'd0);
    checkOutput("t5HaltRetired", {16'd0, retired}, 32'd1);

    $display("[TB] div timeout");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h0085101A, 0);
    n = 0;
    while (!error && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4MdwaitCycles", 32'(n - 1), 32'd64);
    checkOutput("t4Flags", {29'd0, halted, error, busy}, 32'd6);
    sawReq = 1'b0;
    repeat (10) begin
      @(negedge clk);
      sawReq |= imem_req;
    end
    checkOutput("t4NoReq", {31'd0, sawReq}, 32'd0);
    checkOutput("sbDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
